// File: rtl/unpacked_stream_arbiter_if.sv
// Handshake bundle for the unpacked stream arbiter: NUM_IN requester lanes in,
// one registered unpacked beat out.
interface unpacked_stream_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned IN_SIZE    = 16,
    parameter int unsigned NUM_IN     = 4,
    parameter int unsigned SRC_W      = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
);
    // Element i of requester r lives at index r*IN_SIZE+i.
    logic [DATA_WIDTH-1:0] in_data [NUM_IN*IN_SIZE];
    logic [NUM_IN-1:0]     in_last;
    logic [NUM_IN-1:0]     in_valid;
    logic [NUM_IN-1:0]     in_ready;

    logic [DATA_WIDTH-1:0] out_data [IN_SIZE];
    logic                  out_last;
    logic [SRC_W-1:0]      out_src;
    logic                  out_valid;
    logic                  out_ready;

    // Producer side plus output consumer (environment view).
    modport master (
        output in_data, in_last, in_valid, out_ready,
        input  in_ready, out_data, out_last, out_src, out_valid
    );

    // Arbiter view.
    modport slave (
        input  in_data, in_last, in_valid, out_ready,
        output in_ready, out_data, out_last, out_src, out_valid
    );
endinterface

// File: rtl/unpacked_stream_arbiter.sv
// Round-robin, packet-locked arbiter sharing one registered unpacked-array
// stream output between NUM_IN requesters.
module unpacked_stream_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned IN_SIZE    = 16,
    parameter int unsigned NUM_IN     = 4,
    parameter int unsigned SRC_W      = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input logic                      clk,
    input logic                      rst,
    unpacked_stream_arbiter_if.slave bus
);

    typedef enum logic [0:0] {StIdle, StLocked} state_e;

    state_e                state_q;
    logic [SRC_W-1:0]      rr_ptr_q;
    logic [SRC_W-1:0]      locked_src_q;
    logic [DATA_WIDTH-1:0] out_data_q [IN_SIZE];
    logic                  out_last_q;
    logic [SRC_W-1:0]      out_src_q;
    logic                  out_valid_q;

    logic                  load_en;
    logic                  grant_valid;
    logic                  transfer;
    logic                  grant_last;
    logic [SRC_W-1:0]      grant;
    logic [SRC_W-1:0]      grant_next;
    logic [DATA_WIDTH-1:0] grant_data [IN_SIZE];
    logic [31:0]           cand;

    // Pick the winner: locked owner only, otherwise first valid from rr_ptr upward.
    always_comb begin
        grant_valid = 1'b0;
        grant       = '0;
        cand        = '0;
        if (state_q == StLocked) begin
            grant       = locked_src_q;
            grant_valid = bus.in_valid[locked_src_q];
        end else begin
            for (int unsigned k = 0; k < NUM_IN; k++) begin
                // Wrap at NUM_IN, not at 2**SRC_W.
                cand = 32'(rr_ptr_q) + k;
                if (cand >= NUM_IN) begin
                    cand = cand - NUM_IN;
                end
                if (!grant_valid && bus.in_valid[cand]) begin
                    grant_valid = 1'b1;
                    grant       = SRC_W'(cand);
                end
            end
        end
    end

    // Handshake, winner's beat mux and pointer successor.
    always_comb begin
        load_en    = !out_valid_q || bus.out_ready;
        transfer   = !rst && load_en && grant_valid;
        grant_next = (grant == SRC_W'(NUM_IN - 1)) ? '0 : grant + 1'b1;
        grant_last = bus.in_last[grant];
        bus.in_ready = '0;
        for (int unsigned r = 0; r < NUM_IN; r++) begin
            bus.in_ready[r] = transfer && (grant == SRC_W'(r));
        end
        for (int unsigned i = 0; i < IN_SIZE; i++) begin
            grant_data[i] = bus.in_data[32'(grant) * IN_SIZE + i];
        end
    end

    // Output register drives the stream outputs directly.
    always_comb begin
        bus.out_data  = out_data_q;
        bus.out_last  = out_last_q;
        bus.out_src   = out_src_q;
        bus.out_valid = out_valid_q;
    end

    // Output register plus arbitration FSM; rr_ptr only advances on packet end.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            rr_ptr_q     <= '0;
            locked_src_q <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_src_q    <= '0;
            out_data_q   <= '{default: '0};
        end else begin
            if (transfer) begin
                out_data_q  <= grant_data;
                out_last_q  <= grant_last;
                out_src_q   <= grant;
                out_valid_q <= 1'b1;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end

            case (state_q)
                StIdle: begin
                    if (transfer) begin
                        if (grant_last) begin
                            rr_ptr_q <= grant_next;
                        end else begin
                            state_q      <= StLocked;
                            locked_src_q <= grant;
                        end
                    end
                end
                StLocked: begin
                    if (transfer && grant_last) begin
                        state_q  <= StIdle;
                        rr_ptr_q <= grant_next;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_unpacked_stream_arbiter.sv
// Randomized scoreboard bench: two arbiters (4 and 3 requesters) driven by
// packet generators and checked against a packet-level round-robin model.
module tb_unpacked_stream_arbiter;

    localparam int unsigned DW     = 32;
    localparam int unsigned MAX_IN = 4;
    localparam int unsigned MAX_SZ = 16;
    localparam int unsigned NA     = 4;
    localparam int unsigned SA     = 16;
    localparam int unsigned NB     = 3;
    localparam int unsigned SB     = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    unpacked_stream_arbiter_if #(.DATA_WIDTH(DW), .IN_SIZE(SA), .NUM_IN(NA), .SRC_W(2)) bus_a ();
    unpacked_stream_arbiter_if #(.DATA_WIDTH(DW), .IN_SIZE(SB), .NUM_IN(NB), .SRC_W(2)) bus_b ();

    unpacked_stream_arbiter #(.DATA_WIDTH(DW), .IN_SIZE(SA), .NUM_IN(NA), .SRC_W(2)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    unpacked_stream_arbiter #(.DATA_WIDTH(DW), .IN_SIZE(SB), .NUM_IN(NB), .SRC_W(2)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    typedef struct packed {
        logic [MAX_SZ-1:0][DW-1:0] data;
        logic                      last;
        logic [3:0]                src;
    } beat_t;

    // Requester state: head beat on offer and beats left in current packet.
    beat_t head      [2][MAX_IN];
    int    remaining [2][MAX_IN];
    bit    drv_valid [2][MAX_IN];
    bit    drv_oready[2];

    // Reference model: pointer, lock owner and expected output beats.
    int    ptr   [2];
    bit    locked[2];
    int    lsrc  [2];
    beat_t pend  [2];
    bit    pend_v[2];
    bit    clr   [2];
    beat_t exp_q [2][$];

    int valid_pct;
    int ready_pct;
    int max_len;
    bit dead_mode;
    bit rst_req;

    int checks;
    int errors;

    function automatic int nin(int d);
        return (d == 0) ? int'(NA) : int'(NB);
    endfunction

    function automatic int nsz(int d);
        return (d == 0) ? int'(SA) : int'(SB);
    endfunction

    task automatic check(string name, int d, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s dut%0d t=%0t actual %0h required %0h", name, d, $time, act, req);
        end
    endtask

    task automatic check_beat(int d, beat_t act, beat_t req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL beat dut%0d t=%0t actual last=%0b src=%0d data=%h required last=%0b src=%0d data=%h",
                     d, $time, act.last, act.src, act.data, req.last, req.src, req.data);
        end
    endtask

    task automatic new_head(int d, int r);
        beat_t b;
        if (remaining[d][r] == 0) begin
            remaining[d][r] = int'($urandom_range(max_len, 1));
        end
        b = '0;
        for (int i = 0; i < nsz(d); i++) begin
            b.data[i] = $urandom;
        end
        if (dead_mode) begin
            b.data[0] = 32'hDEADBEEF;
        end
        b.last = (remaining[d][r] == 1);
        b.src  = 4'(r);
        head[d][r] = b;
    endtask

    task automatic apply_inputs();
        for (int r = 0; r < int'(NA); r++) begin
            bus_a.in_valid[r] = drv_valid[0][r];
            bus_a.in_last[r]  = head[0][r].last;
            for (int i = 0; i < int'(SA); i++) begin
                bus_a.in_data[r*SA+i] = head[0][r].data[i];
            end
        end
        bus_a.out_ready = drv_oready[0];
        for (int r = 0; r < int'(NB); r++) begin
            bus_b.in_valid[r] = drv_valid[1][r];
            bus_b.in_last[r]  = head[1][r].last;
            for (int i = 0; i < int'(SB); i++) begin
                bus_b.in_data[r*SB+i] = head[1][r].data[i];
            end
        end
        bus_b.out_ready = drv_oready[1];
    endtask

    function automatic int get_ready(int d);
        return (d == 0) ? int'(bus_a.in_ready) : int'(bus_b.in_ready);
    endfunction

    task automatic get_out(int d, output beat_t b, output bit v);
        b = '0;
        if (d == 0) begin
            v      = bus_a.out_valid;
            b.last = bus_a.out_last;
            b.src  = 4'(bus_a.out_src);
            for (int i = 0; i < int'(SA); i++) b.data[i] = bus_a.out_data[i];
        end else begin
            v      = bus_b.out_valid;
            b.last = bus_b.out_last;
            b.src  = 4'(bus_b.out_src);
            for (int i = 0; i < int'(SB); i++) b.data[i] = bus_b.out_data[i];
        end
    endtask

    // Decide this cycle's grant from the round-robin/packet rules and predict in_ready.
    task automatic model_step(int d);
        int n;
        int g;
        int req_mask;
        bit room;
        n        = nin(d);
        g        = -1;
        req_mask = 0;
        if (!rst) begin
            if (locked[d]) begin
                if (drv_valid[d][lsrc[d]]) g = lsrc[d];
            end else begin
                for (int k = 0; k < n; k++) begin
                    if (g < 0 && drv_valid[d][(ptr[d] + k) % n]) g = (ptr[d] + k) % n;
                end
            end
            room = (exp_q[d].size() == 0) || drv_oready[d];
            if (!room) g = -1;
            if (g >= 0) req_mask = 1 << g;
        end
        check("in_ready", d, get_ready(d), req_mask);
        if (rst) begin
            clr[d]    = 1'b1;
            ptr[d]    = 0;
            locked[d] = 1'b0;
            lsrc[d]   = 0;
            for (int r = 0; r < n; r++) begin
                remaining[d][r] = 0;
                new_head(d, r);
            end
        end else if (g >= 0) begin
            pend[d]   = head[d][g];
            pend_v[d] = 1'b1;
            if (head[d][g].last) begin
                locked[d] = 1'b0;
                ptr[d]    = (g + 1) % n;
            end else begin
                locked[d] = 1'b1;
                lsrc[d]   = g;
            end
            remaining[d][g]--;
            new_head(d, g);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            if (clr[d]) begin
                exp_q[d].delete();
                clr[d] = 1'b0;
            end
            if (pend_v[d]) begin
                exp_q[d].push_back(pend[d]);
                pend_v[d] = 1'b0;
            end
        end
        #1;
        rst = rst_req;
        for (int d = 0; d < 2; d++) begin
            for (int r = 0; r < nin(d); r++) begin
                drv_valid[d][r] = (int'($urandom_range(99, 0)) < valid_pct);
            end
            drv_oready[d] = (int'($urandom_range(99, 0)) < ready_pct);
        end
        apply_inputs();
        #1;
        for (int d = 0; d < 2; d++) model_step(d);
    endtask

    // Monitor: whenever a beat is presented it must be the oldest expected one.
    initial begin
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                beat_t b;
                bit    v;
                get_out(d, b, v);
                check("out_valid", d, int'(v), int'(exp_q[d].size() != 0));
                if (v && exp_q[d].size() != 0) begin
                    check_beat(d, b, exp_q[d][0]);
                    if (drv_oready[d]) void'(exp_q[d].pop_front());
                end
            end
        end
    end

    initial begin
        checks    = 0;
        errors    = 0;
        valid_pct = 100;
        ready_pct = 100;
        max_len   = 1;
        dead_mode = 1'b0;
        rst_req   = 1'b1;
        for (int d = 0; d < 2; d++) begin
            ptr[d]        = 0;
            locked[d]     = 1'b0;
            lsrc[d]       = 0;
            pend_v[d]     = 1'b0;
            clr[d]        = 1'b0;
            drv_oready[d] = 1'b1;
            for (int r = 0; r < int'(MAX_IN); r++) begin
                remaining[d][r] = 0;
                drv_valid[d][r] = 1'b1;
                new_head(d, r);
            end
        end
        apply_inputs();

        // Reset held with every requester valid.
        repeat (2) cycle();
        rst_req = 1'b0;

        // Continuous single-beat packets from everyone: strict rotation, no bubbles.
        repeat (12) cycle();

        // Multi-beat packets under full contention: grants stay locked.
        max_len = 3;
        repeat (30) cycle();

        // Output stalled while a beat is held.
        dead_mode = 1'b1;
        repeat (3) cycle();
        ready_pct = 0;
        repeat (5) cycle();
        ready_pct = 100;
        dead_mode = 1'b0;
        repeat (5) cycle();

        // Random valids and backpressure.
        valid_pct = 60;
        ready_pct = 70;
        max_len   = 4;
        repeat (1500) cycle();

        // Reset in the middle of traffic, then resume with everyone valid.
        valid_pct = 100;
        repeat (2) cycle();
        rst_req = 1'b1;
        cycle();
        rst_req = 1'b0;
        repeat (10) cycle();

        valid_pct = 50;
        ready_pct = 60;
        repeat (1500) cycle();

        // Drain.
        valid_pct = 0;
        ready_pct = 100;
        repeat (5) cycle();

        @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
